// File: rtl/speed_select_ctrl_if.sv
// Key/speed bundle between the pushbutton front-end and the speed control stage.
//   KeyUp, KeyDown  raw active-low pushbuttons, asynchronous to the stage clock
//   Speed           2-bit speed code for the rate-divided counter
//   SpeedChanged    one-cycle strobe, Speed took a new value on the previous edge
// Modports:
//   master  drives the keys and observes Speed (button source / testbench)
//   slave   the control stage itself
interface speed_select_ctrl_if;
    logic       KeyUp;
    logic       KeyDown;
    logic [1:0] Speed;
    logic       SpeedChanged;

    modport master (
        output KeyUp,
        output KeyDown,
        input  Speed,
        input  SpeedChanged
    );

    modport slave (
        input  KeyUp,
        input  KeyDown,
        output Speed,
        output SpeedChanged
    );
endinterface

// File: rtl/speed_select_ctrl.sv
// Speed select control: turns two raw pushbuttons into the 2-bit Speed code of the
// rate-divided hex counter. Each key is synchronised (two flops) and debounced; one
// clean press steps Speed up or down by one, with a one-cycle SpeedChanged strobe.
// Ports:
//   ClockIn  system clock
//   Reset    synchronous active-low reset
//   bus      speed_select_ctrl_if.slave (KeyUp, KeyDown in; Speed, SpeedChanged out)
// Parameters:
//   CW               width of each debounce counter (must hold DEBOUNCE_CYCLES-1)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key level is accepted (>= 2)
//   RESET_SPEED      Speed value loaded on reset
// Build option:
//   SPEED_WRAP_EN    when defined, up at 11 wraps to 00 and down at 00 wraps to 11;
//                    otherwise Speed saturates at both ends.
module speed_select_ctrl #(
    parameter int unsigned    CW              = 20,
    parameter logic [CW-1:0]  DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [1:0]     RESET_SPEED     = 2'b00
) (
    input logic                ClockIn,
    input logic                Reset,
    speed_select_ctrl_if.slave bus
);

    localparam logic [CW-1:0] TERMINAL = DEBOUNCE_CYCLES - CW'(1);

    // Bit 0 is KeyUp, bit 1 is KeyDown; both paths are identical and independent.
    logic [1:0]    key_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_dly;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    logic          up_press;
    logic          dn_press;

    logic [1:0]    speed_q;
    logic [1:0]    speed_d;
    logic          changed_q;

    assign key_raw = {bus.KeyDown, bus.KeyUp};

    always_ff @(posedge ClockIn) begin
        if (!Reset) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            deb     <= 2'b11;
            deb_dly <= 2'b11;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            deb_dly <= deb;
            for (int i = 0; i < 2; i++) begin
                // Any return to the accepted level restarts the stability count.
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TERMINAL) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Only the debounced 1->0 edge counts; holding or releasing the key does nothing.
    assign press    = deb_dly & ~deb;
    assign up_press = press[0];
    assign dn_press = press[1];

    always_comb begin
        speed_d = speed_q;
        if (up_press && !dn_press) begin
`ifdef SPEED_WRAP_EN
            speed_d = speed_q + 2'd1;
`else
            if (speed_q != 2'b11) begin
                speed_d = speed_q + 2'd1;
            end
`endif
        end else if (dn_press && !up_press) begin
`ifdef SPEED_WRAP_EN
            speed_d = speed_q - 2'd1;
`else
            if (speed_q != 2'b00) begin
                speed_d = speed_q - 2'd1;
            end
`endif
        end
    end

    always_ff @(posedge ClockIn) begin
        if (!Reset) begin
            speed_q   <= RESET_SPEED;
            changed_q <= 1'b0;
        end else begin
            speed_q   <= speed_d;
            changed_q <= (speed_d != speed_q);
        end
    end

    assign bus.Speed        = speed_q;
    assign bus.SpeedChanged = changed_q;

endmodule
